// File: rtl/gelu_scheduler.sv
// gelu_scheduler: round-robin burst arbiter sharing one gelu pipeline with tagged, drain-guarded coefficient switches
module gelu_scheduler #(
  parameter int D_W   = 32,
  parameter int NREQ  = 4,
  parameter int LEN_W = 16,
  parameter int LAT   = 8,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*D_W-1:0]   cfg_qb,
  input  logic [NREQ*D_W-1:0]   cfg_qc,
  input  logic [NREQ*D_W-1:0]   cfg_q1,
  output logic [NREQ-1:0]       grant,
  input  logic [NREQ-1:0]       s_valid,
  input  logic [NREQ*D_W-1:0]   s_data,
  output logic [NREQ-1:0]       s_ready,
  output logic [NREQ-1:0]       done,
  output logic                  g_in_valid,
  output logic                  g_enable,
  output logic [D_W-1:0]        g_qin,
  output logic [D_W-1:0]        g_qb,
  output logic [D_W-1:0]        g_qc,
  output logic [D_W-1:0]        g_q1,
  input  logic                  g_out_valid,
  input  logic [D_W-1:0]        g_qout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [D_W-1:0]        m_data,
  output logic [ID_W-1:0]       m_id,
  output logic                  m_last
);
  localparam int IF_W = $clog2(LAT + 1);
  typedef enum logic [2:0] {IDLE, ARB, DRAIN, LOAD, STREAM} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] rr, cur_id, pick, zl_id;
  logic found, zl_v, issue, accept;
  logic [LEN_W-1:0] rem, pick_len;
  logic [D_W-1:0] sqb, sqc, sq1;
  logic [IF_W-1:0] inflight;
  logic [LAT-1:0] tv, tl;
  logic [LAT-1:0][ID_W-1:0] tid;
  // stale gelu outputs left over from a reset carry an invalid tag and are never presented
  assign m_valid = g_out_valid && tv[LAT-1];
  assign m_data = g_qout;
  assign m_id = tid[LAT-1];
  assign m_last = tl[LAT-1];
  assign accept = m_valid && m_ready;
  assign g_enable = rst || !(m_valid && !m_ready);
  assign issue = !rst && state == STREAM && s_valid[cur_id] && g_enable;
  assign g_in_valid = issue;
  assign g_qin = issue ? s_data[cur_id*D_W +: D_W] : '0;
  assign s_ready = (!rst && state == STREAM) ? NREQ'(g_enable) << cur_id : '0;
  assign grant = (!rst && state == ARB && found) ? NREQ'(1) << pick : '0;
  assign done = rst ? '0 : (zl_v ? NREQ'(1) << zl_id : '0) | (accept && m_last ? NREQ'(1) << m_id : '0);
  assign pick_len = req_len[pick*LEN_W +: LEN_W];
  // first pending requester at or after the rr pointer; descending scan lets the nearest one win
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(rr) + i) % NREQ]) begin
        pick = ID_W'((int'(rr) + i) % NREQ);
        found = 1'b1;
      end
  end
  // burst sequencing: arbitrate, drain the pipe, load coefficients, stream
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |req ? ARB : IDLE;
      ARB:     state_n = (found && pick_len != '0) ? DRAIN : IDLE;
      DRAIN:   state_n = inflight == '0 ? LOAD : DRAIN;
      LOAD:    state_n = STREAM;
      STREAM:  state_n = (issue && rem == LEN_W'(1)) ? IDLE : STREAM;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // grant shadow, coefficient load, burst counter and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
      cur_id <= '0;
      rem <= '0;
      sqb <= '0;
      sqc <= '0;
      sq1 <= '0;
      g_qb <= '0;
      g_qc <= '0;
      g_q1 <= '0;
      zl_v <= 1'b0;
      zl_id <= '0;
      inflight <= '0;
    end else begin
      zl_v <= state == ARB && found && pick_len == '0;
      zl_id <= pick;
      if (state == ARB && found) begin
        cur_id <= pick;
        rem <= pick_len;
        sqb <= cfg_qb[pick*D_W +: D_W];
        sqc <= cfg_qc[pick*D_W +: D_W];
        sq1 <= cfg_q1[pick*D_W +: D_W];
        rr <= pick == ID_W'(NREQ - 1) ? '0 : pick + 1'b1;
      end
      if (state == LOAD) begin
        g_qb <= sqb;
        g_qc <= sqc;
        g_q1 <= sq1;
      end
      if (issue) rem <= rem - 1'b1;
      inflight <= inflight + IF_W'(issue) - IF_W'(accept);
    end
  end
  // tag pipe tracks gelu stage for stage, frozen together with it
  always_ff @(posedge clk) begin
    if (rst) begin
      tv <= '0;
      tl <= '0;
      tid <= '0;
    end else if (g_enable) begin
      tv <= {tv[LAT-2:0], issue};
      tl <= {tl[LAT-2:0], issue && rem == LEN_W'(1)};
      tid <= {tid[LAT-2:0], cur_id};
    end
  end
endmodule

// File: tb/tb_gelu_scheduler.sv
// tb_gelu_scheduler: randomized bursts against a gelu pipe model and a round-robin scoreboard
module tb_gelu_scheduler;
  localparam int D_W = 32, NREQ = 4, LEN_W = 16, LAT = 8, ID_W = 2;
  typedef struct packed {logic [ID_W-1:0] id; logic [D_W-1:0] d; logic last;} res_t;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req = '0, s_valid = '0, grant, s_ready, done;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [NREQ*D_W-1:0] cfg_qb = '0, cfg_qc = '0, cfg_q1 = '0, s_data = '0;
  logic g_in_valid, g_enable, g_out_valid, m_valid, m_last;
  logic m_ready = 1;
  logic [D_W-1:0] g_qin, g_qb, g_qc, g_q1, g_qout, m_data;
  logic [ID_W-1:0] m_id;
  gelu_scheduler #(.D_W(D_W), .NREQ(NREQ), .LEN_W(LEN_W), .LAT(LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .cfg_qb(cfg_qb), .cfg_qc(cfg_qc),
    .cfg_q1(cfg_q1), .grant(grant), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .done(done), .g_in_valid(g_in_valid), .g_enable(g_enable), .g_qin(g_qin), .g_qb(g_qb),
    .g_qc(g_qc), .g_q1(g_q1), .g_out_valid(g_out_valid), .g_qout(g_qout), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .m_last(m_last));
  always #5 clk = ~clk;

  // gelu model: LAT enabled stages, coefficients applied at the output (qc is not pipelined)
  logic [LAT-1:0] gv = '0;
  logic [D_W-1:0] gd [LAT];
  always @(posedge clk) if (g_enable) begin
    gv <= {gv[LAT-2:0], g_in_valid};
    gd[0] <= g_qin;
    for (int k = 1; k < LAT; k++) gd[k] <= gd[k-1];
  end
  assign g_out_valid = gv[LAT-1];
  assign g_qout = (gd[LAT-1] * g_qc + g_qb) ^ g_q1;

  function automatic logic [D_W-1:0] gelu_ref(input logic [D_W-1:0] x, qb, qc, q1);
    return (x * qc + qb) ^ q1;
  endfunction

  int tests = 0, fails = 0;
  int cyc = 0, occ = 0, max_occ = 0, issues = 0, qc_bad = 0, mrr = 0;
  int done_cnt [NREQ];
  int grant_q[$], iss_t[$], lat_q[$], order_q[$];
  res_t got_q[$], exp_all[$];
  res_t expq [NREQ][$];
  logic [D_W-1:0] srcq [NREQ][$];
  logic [D_W-1:0] cqb [NREQ], cqc [NREQ], cq1 [NREQ];
  logic [D_W-1:0] prev_qc = '0;
  bit bubble = 0;

  // observer: accepted results, issues, occupancy, grants, dones, qc changes
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      occ = 0;
      got_q.delete();
      iss_t.delete();
      prev_qc = g_qc;
    end else begin
      if (g_qc !== prev_qc && occ != 0) qc_bad++;
      prev_qc = g_qc;
      if (g_in_valid && g_enable) begin
        issues++;
        occ++;
        iss_t.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        got_q.push_back(res_t'{m_id, m_data, m_last});
        occ--;
        if (iss_t.size() > 0) lat_q.push_back(cyc - iss_t.pop_front());
      end
      if (occ > max_occ) max_occ = occ;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) done_cnt[i]++;
        if (grant[i]) grant_q.push_back(i);
      end
    end
  end

  // sources: hold data until accepted, drop req after grant, optional bubble pattern 1,0,0,1,0,1
  initial begin
    logic [NREQ-1:0] fire, gr;
    logic [5:0] pat;
    int pi;
    pat = 6'b101001;
    pi = 0;
    forever begin
      @(negedge clk);
      fire = s_valid & s_ready;
      gr = grant;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gr[i]) req[i] = 1'b0;
        if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        s_valid[i] = srcq[i].size() > 0 && (!bubble || pat[pi % 6]);
        s_data[i*D_W +: D_W] = srcq[i].size() > 0 ? srcq[i][0] : '0;
      end
      pi++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic add_burst(input int id, input int len, input logic [D_W-1:0] qb, qc, q1);
    logic [D_W-1:0] d;
    req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
    cfg_qb[id*D_W +: D_W] = qb;
    cfg_qc[id*D_W +: D_W] = qc;
    cfg_q1[id*D_W +: D_W] = q1;
    cqb[id] = qb;
    cqc[id] = qc;
    cq1[id] = q1;
    for (int k = 0; k < len; k++) begin
      d = $urandom;
      srcq[id].push_back(d);
      expq[id].push_back(res_t'{ID_W'(id), gelu_ref(d, qb, qc, q1), k == len - 1});
    end
    req[id] = 1'b1;
  endtask

  // round-robin reference: pending requesters served in pointer order, results concatenated per burst
  function automatic void plan(input logic [NREQ-1:0] mask);
    int k;
    order_q.delete();
    exp_all.delete();
    for (int i = 0; i < NREQ; i++) begin
      k = (mrr + i) % NREQ;
      if (mask[k]) order_q.push_back(k);
    end
    foreach (order_q[j]) begin
      foreach (expq[order_q[j]][e]) exp_all.push_back(expq[order_q[j]][e]);
      expq[order_q[j]].delete();
    end
    if (order_q.size() > 0) mrr = (order_q[order_q.size()-1] + 1) % NREQ;
  endfunction

  task automatic clear_obs();
    got_q.delete();
    grant_q.delete();
    lat_q.delete();
    iss_t.delete();
    issues = 0;
    max_occ = 0;
    qc_bad = 0;
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    tests++; if (grant !== '0) begin fails++; $display("FAIL reset_grant got %b exp 0", grant); end
    tests++; if (s_ready !== '0) begin fails++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
    tests++; if (done !== '0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (g_in_valid !== 1'b0) begin fails++; $display("FAIL reset_in_valid got %b exp 0", g_in_valid); end
    tests++; if (g_enable !== 1'b1) begin fails++; $display("FAIL reset_enable got %b exp 1", g_enable); end
    tests++; if ({g_qb, g_qc, g_q1, g_qin} !== '0) begin fails++; $display("FAIL reset_coef got %h %h %h %h exp 0", g_qb, g_qc, g_q1, g_qin); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    tests++; if (grant !== '0 || s_ready !== '0) begin fails++; $display("FAIL post_reset_idle got grant=%b s_ready=%b exp 0", grant, s_ready); end
  endtask

  task automatic test_single();
    clear_obs();
    @(posedge clk); #2;
    add_burst(0, 4, 32'hFFFF_FFFE, 32'd1, 32'd1);
    plan(4'b0001);
    wait_results(4, 200);
    tests++; if (grant_q.size() != 1 || grant_q[0] != 0) begin fails++; $display("FAIL single_grant got %0d grants exp one grant to 0", grant_q.size()); end
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL single_count got %0d exp 4", got_q.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= got_q.size() || got_q[k] !== exp_all[k]) begin
        fails++;
        $display("FAIL single_result[%0d] got %h exp %h", k, k < got_q.size() ? got_q[k] : '0, exp_all[k]);
      end
    end
    foreach (lat_q[k]) begin
      tests++; if (lat_q[k] != LAT) begin fails++; $display("FAIL single_latency[%0d] got %0d exp %0d", k, lat_q[k], LAT); end
    end
    tests++; if (issues != 4) begin fails++; $display("FAIL single_issues got %0d exp 4", issues); end
    tests++; if (done_cnt[0] != 1 || done_cnt[1] + done_cnt[2] + done_cnt[3] != 0) begin fails++; $display("FAIL single_done got %0d exp 1", done_cnt[0]); end
  endtask

  task automatic test_round_robin();
    rst = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 0;
    mrr = 0;
    clear_obs();
    @(posedge clk); #2;
    for (int i = 0; i < NREQ; i++) add_burst(i, 2, $urandom, $urandom, $urandom);
    plan(4'b1111);
    wait_results(8, 500);
    tests++; if (grant_q.size() != 4) begin fails++; $display("FAIL rr_grant_count got %0d exp 4", grant_q.size()); end
    for (int j = 0; j < 4; j++) begin
      tests++; if (j >= grant_q.size() || grant_q[j] != order_q[j]) begin fails++; $display("FAIL rr_grant_order[%0d] got %0d exp %0d", j, j < grant_q.size() ? grant_q[j] : -1, order_q[j]); end
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (k >= got_q.size() || got_q[k] !== exp_all[k]) begin
        fails++;
        $display("FAIL rr_result[%0d] got %h exp %h", k, k < got_q.size() ? got_q[k] : '0, exp_all[k]);
      end
    end
    tests++; if (qc_bad != 0) begin fails++; $display("FAIL rr_qc_change_nonempty got %0d exp 0", qc_bad); end
    for (int i = 0; i < NREQ; i++) begin
      tests++; if (done_cnt[i] != 1) begin fails++; $display("FAIL rr_done[%0d] got %0d exp 1", i, done_cnt[i]); end
    end
  endtask

  int bp_id;
  task automatic test_backpressure();
    logic [D_W-1:0] hd;
    logic [ID_W-1:0] hid;
    int k;
    clear_obs();
    bp_id = $urandom_range(0, NREQ - 1);
    @(posedge clk); #2;
    add_burst(bp_id, 6, $urandom, $urandom, $urandom);
    plan(NREQ'(1) << bp_id);
    for (k = 0; k < 200 && !m_valid; k++) @(negedge clk);
    tests++; if (!m_valid) begin fails++; $display("FAIL bp_first_result got none exp m_valid"); end
    @(posedge clk); #1 m_ready = 0;
    hd = exp_all[1].d;
    hid = ID_W'(bp_id);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++; if (g_enable !== 1'b0) begin fails++; $display("FAIL bp_enable[%0d] got %b exp 0", c, g_enable); end
      tests++; if (m_data !== hd || m_id !== hid) begin fails++; $display("FAIL bp_hold[%0d] got %h/%0d exp %h/%0d", c, m_data, m_id, hd, hid); end
    end
    @(posedge clk); #1 m_ready = 1;
    @(negedge clk);
    tests++; if (g_enable !== 1'b1) begin fails++; $display("FAIL bp_release got %b exp 1", g_enable); end
    wait_results(6, 200);
    tests++; if (got_q.size() != 6) begin fails++; $display("FAIL bp_count got %0d exp 6", got_q.size()); end
    for (int j = 0; j < 6; j++) begin
      tests++;
      if (j >= got_q.size() || got_q[j] !== exp_all[j]) begin
        fails++;
        $display("FAIL bp_result[%0d] got %h exp %h", j, j < got_q.size() ? got_q[j] : '0, exp_all[j]);
      end
    end
    tests++; if (max_occ > LAT || issues != 6) begin fails++; $display("FAIL bp_occupancy got max=%0d issues=%0d exp <=%0d, 6", max_occ, issues, LAT); end
    tests++; if (done_cnt[bp_id] != 1) begin fails++; $display("FAIL bp_done got %0d exp 1", done_cnt[bp_id]); end
  endtask

  task automatic test_zero_len();
    logic [D_W-1:0] eb, ec, e1;
    int k;
    eb = cqb[bp_id];
    ec = cqc[bp_id];
    e1 = cq1[bp_id];
    clear_obs();
    @(posedge clk); #2;
    add_burst(2, 0, $urandom, $urandom, $urandom);
    plan(4'b0100);
    for (k = 0; k < 50 && grant == '0; k++) @(negedge clk);
    tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL zl_grant got %b exp 0100", grant); end
    @(negedge clk);
    tests++; if (done !== 4'b0100) begin fails++; $display("FAIL zl_done got %b exp 0100", done); end
    repeat (10) @(negedge clk);
    tests++; if (issues != 0 || got_q.size() != 0) begin fails++; $display("FAIL zl_no_issue got issues=%0d results=%0d exp 0", issues, got_q.size()); end
    tests++; if (g_qb !== eb || g_qc !== ec || g_q1 !== e1) begin fails++; $display("FAIL zl_coef got %h %h %h exp %h %h %h", g_qb, g_qc, g_q1, eb, ec, e1); end
    tests++; if (done_cnt[2] != 1) begin fails++; $display("FAIL zl_done_count got %0d exp 1", done_cnt[2]); end
  endtask

  task automatic test_bubbles();
    int id;
    clear_obs();
    id = $urandom_range(0, NREQ - 1);
    bubble = 1;
    @(posedge clk); #2;
    add_burst(id, 3, $urandom, $urandom, $urandom);
    plan(NREQ'(1) << id);
    wait_results(3, 300);
    bubble = 0;
    tests++; if (issues != 3) begin fails++; $display("FAIL bub_issues got %0d exp 3", issues); end
    tests++; if (got_q.size() != 3) begin fails++; $display("FAIL bub_count got %0d exp 3", got_q.size()); end
    for (int j = 0; j < 3; j++) begin
      tests++;
      if (j >= got_q.size() || got_q[j] !== exp_all[j]) begin
        fails++;
        $display("FAIL bub_result[%0d] got %h exp %h", j, j < got_q.size() ? got_q[j] : '0, exp_all[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int id, k, stale;
    clear_obs();
    id = $urandom_range(0, NREQ - 1);
    @(posedge clk); #2;
    add_burst(id, 10, $urandom, $urandom, $urandom);
    plan(NREQ'(1) << id);
    for (k = 0; k < 200 && occ != 5; k++) begin @(negedge clk); #1; end
    tests++; if (occ != 5) begin fails++; $display("FAIL rm_reach_inflight got %0d exp 5", occ); end
    rst = 1;
    @(negedge clk);
    tests++; if (m_valid !== 1'b0 || grant !== '0 || g_in_valid !== 1'b0) begin fails++; $display("FAIL rm_during got m_valid=%b grant=%b in_valid=%b exp 0", m_valid, grant, g_in_valid); end
    @(posedge clk); #1 rst = 0;
    srcq[id].delete();
    mrr = 0;
    @(negedge clk);
    tests++; if (m_valid !== 1'b0 || s_ready !== '0) begin fails++; $display("FAIL rm_after got m_valid=%b s_ready=%b exp 0", m_valid, s_ready); end
    stale = 0;
    for (int c = 0; c < LAT + 4; c++) begin @(negedge clk); if (m_valid) stale++; end
    tests++; if (stale != 0) begin fails++; $display("FAIL rm_stale got %0d exp 0", stale); end
    clear_obs();
    id = $urandom_range(0, NREQ - 1);
    @(posedge clk); #2;
    add_burst(id, 4, $urandom, $urandom, $urandom);
    plan(NREQ'(1) << id);
    wait_results(4, 200);
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL rm_count got %0d exp 4", got_q.size()); end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (j >= got_q.size() || got_q[j] !== exp_all[j]) begin
        fails++;
        $display("FAIL rm_result[%0d] got %h exp %h", j, j < got_q.size() ? got_q[j] : '0, exp_all[j]);
      end
    end
    tests++; if (done_cnt[id] != 1) begin fails++; $display("FAIL rm_done got %0d exp 1", done_cnt[id]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_len();
    test_bubbles();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
